// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, func3 codes and arbiter state encodings for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int AddrWidth  = 32;
  localparam int DataWidth  = 32;
  localparam int Func3Width = 3;

  localparam logic [Func3Width-1:0] F3_B  = 3'd0;
  localparam logic [Func3Width-1:0] F3_H  = 3'd1;
  localparam logic [Func3Width-1:0] F3_W  = 3'd2;
  localparam logic [Func3Width-1:0] F3_BU = 3'd4;
  localparam logic [Func3Width-1:0] F3_HU = 3'd5;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_LOCK1 = 1'b1
  } arb_state_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_mem_access_check.sv
// Combinational legality check of one memory access: width code, alignment and store width.
module mem_access_check
  import dmem_arbiter_pkg::*;
(
  input  logic                  we,
  input  logic [Func3Width-1:0] func3,
  input  logic [1:0]            addr,
  output logic                  legal
);

  logic w_fmt_ok;

  // Alignment and encoding legality per width code
  always_comb begin
    w_fmt_ok = 1'b0;
    case (func3)
      F3_B, F3_BU: w_fmt_ok = 1'b1;
      F3_H, F3_HU: w_fmt_ok = (addr != 2'b11);
      F3_W:        w_fmt_ok = (addr == 2'b00);
      default:     w_fmt_ok = 1'b0;
    endcase
  end

  // Unsigned widths exist only for loads
  assign legal = w_fmt_ok & ~(we & (func3 > F3_W));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: port 0 priority,
// bounded wait for port 1, port 1 burst lock, legality check and registered responses.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [Func3Width-1:0] func30,
  input  logic [Func3Width-1:0] func31,
  input  logic [AddrWidth-1:0]  addr0,
  input  logic [AddrWidth-1:0]  addr1,
  input  logic [DataWidth-1:0]  wdata0,
  input  logic [DataWidth-1:0]  wdata1,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  stall0,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DataWidth-1:0]  rdata0,
  output logic [DataWidth-1:0]  rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic                  memWriteEnable,
  output logic [Func3Width-1:0] memFunc3,
  output logic [AddrWidth-1:0]  memAddr,
  output logic [DataWidth-1:0]  memWriteData,
  input  logic [DataWidth-1:0]  memReadData
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  arb_state_e             r_state;
  logic [3:0]             r_wait_cnt;
  logic                   r_rvalid0;
  logic                   r_rvalid1;
  logic [DataWidth-1:0]   r_rdata0;
  logic [DataWidth-1:0]   r_rdata1;
  logic                   r_err0;
  logic                   r_err1;

  logic                   w_pick0;
  logic                   w_pick1;
  logic                   w_we;
  logic                   w_legal;
  logic [Func3Width-1:0]  w_func3;
  logic [AddrWidth-1:0]   w_addr;
  logic [DataWidth-1:0]   w_wdata;
  logic [DataWidth-1:0]   w_load_data;

  // Winner selection; port 1 takes over once it has waited MAX_WAIT cycles
  always_comb begin
    w_pick0 = 1'b0;
    w_pick1 = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (req0 && (r_wait_cnt < LP_MAX_WAIT)) begin
          w_pick0 = 1'b1;
        end else if (req1) begin
          w_pick1 = 1'b1;
        end else begin
          w_pick0 = req0;
        end
      end
      ARB_LOCK1: w_pick1 = req1;
      default: begin
        w_pick0 = 1'b0;
        w_pick1 = 1'b0;
      end
    endcase
  end

  assign gnt0   = w_pick0 & ~rst;
  assign gnt1   = w_pick1 & ~rst;
  assign stall0 = req0 & ~gnt0;

  assign w_we    = gnt1 ? we1    : we0;
  assign w_func3 = gnt1 ? func31 : func30;
  assign w_addr  = gnt1 ? addr1  : addr0;
  assign w_wdata = gnt1 ? wdata1 : wdata0;

  mem_access_check u_check (
    .we    (w_we),
    .func3 (w_func3),
    .addr  (w_addr[1:0]),
    .legal (w_legal)
  );

  assign memWriteEnable = (gnt0 | gnt1) & w_we & w_legal;
  assign memFunc3       = w_func3;
  assign memAddr        = w_addr;
  assign memWriteData   = w_wdata;
  assign w_load_data    = (w_we | ~w_legal) ? {DataWidth{1'b0}} : memReadData;

  // Lock state and port 1 starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      case (r_state)
        ARB_IDLE:  if (gnt1 && lock1)  r_state <= ARB_LOCK1;
        ARB_LOCK1: if (gnt1 && !lock1) r_state <= ARB_IDLE;
        default:   r_state <= ARB_IDLE;
      endcase
      if (gnt1 || !req1) begin
        r_wait_cnt <= 4'd0;
      end else begin
        r_wait_cnt <= sat_inc4(r_wait_cnt);
      end
    end
  end

  // One-cycle response registers, load data captured at the end of the grant cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= {DataWidth{1'b0}};
      r_rdata1  <= {DataWidth{1'b0}};
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
    end else begin
      r_rvalid0 <= gnt0;
      r_rvalid1 <= gnt1;
      r_rdata0  <= gnt0 ? w_load_data : {DataWidth{1'b0}};
      r_rdata1  <= gnt1 ? w_load_data : {DataWidth{1'b0}};
      r_err0    <= gnt0 & ~w_legal;
      r_err1    <= gnt1 & ~w_legal;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
  assign err0    = r_err0;
  assign err1    = r_err1;

endmodule
